fetch_queue: RTL

//   Decoupling queue between the fetch stage and the decode stage.

---
 rtl/fetch_queue_pkg.sv | 29 ++
 rtl/fetch_queue_if.sv | 38 +++
 rtl/fetch_queue_mem.sv | 24 ++
 rtl/fetch_queue.sv | 85 ++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared constants for the fetch queue: NOP encoding, default data width and
// the packed bundle layout {pc, instr, br_pred, pc_pred} (MSB to LSB).
package fetch_queue_pkg;

    localparam int          XLEN_DEFAULT = 32;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;  // addi x0,x0,0

    // Field positions inside one packed bundle, as functions of the data width.
    function automatic int bundle_w(input int xlen);
        return 3 * xlen + 1;
    endfunction

    function automatic int pred_lsb(input int xlen);
        return 0;
    endfunction

    function automatic int br_bit(input int xlen);
        return xlen;
    endfunction

    function automatic int instr_lsb(input int xlen);
        return xlen + 1;
    endfunction

    function automatic int pc_lsb(input int xlen);
        return 2 * xlen + 1;
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode bus: fetch-side push handshake, decode-side pop handshake,
// flush request and occupancy. The queue sits on the slave modport.
interface fetch_queue_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic            flush_i;
    logic            in_valid_i;
    logic            in_ready_o;
    logic [XLEN-1:0] in_pc_i;
    logic [XLEN-1:0] in_instr_i;
    logic            in_br_pred_i;
    logic [XLEN-1:0] in_pc_pred_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [XLEN-1:0] out_pc_o;
    logic [XLEN-1:0] out_instr_o;
    logic            out_br_pred_o;
    logic [XLEN-1:0] out_pc_pred_o;
    logic [CW-1:0]   count_o;

    modport master (
        output flush_i, in_valid_i, in_pc_i, in_instr_i, in_br_pred_i, in_pc_pred_i,
               out_ready_i,
        input  in_ready_o, out_valid_o, out_pc_o, out_instr_o, out_br_pred_o,
               out_pc_pred_o, count_o
    );

    modport slave (
        input  flush_i, in_valid_i, in_pc_i, in_instr_i, in_br_pred_i, in_pc_pred_i,
               out_ready_i,
        output in_ready_o, out_valid_o, out_pc_o, out_instr_o, out_br_pred_o,
               out_pc_pred_o, count_o
    );

endinterface

// File: rtl/fetch_queue_mem.sv
// DEPTH x W register array, one synchronous write port and one asynchronous
// read port. Data carries no reset; occupancy is tracked by the owner.
module fetch_queue_mem #(
    parameter int DEPTH = 4,
    parameter int W     = 97
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem [DEPTH];

    // Write the accepted bundle into its slot.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode decoupling queue. Pointer/count registers are the only state;
// a flush empties the queue so wrong-path bundles never reach decode.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = XLEN_DEFAULT
) (
    input logic           clk,
    input logic           reset_n,
    fetch_queue_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int BW = bundle_w(XLEN);
    localparam int PC_LSB    = pc_lsb(XLEN);
    localparam int INSTR_LSB = instr_lsb(XLEN);
    localparam int BR_BIT    = br_bit(XLEN);
    localparam int PRED_LSB  = pred_lsb(XLEN);
    localparam logic [XLEN-1:0] NOP = XLEN'(NOP_INSTR);

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;
    logic [BW-1:0] wdata;
    logic [BW-1:0] rdata;

    // Ready and valid come only from registered occupancy, never from the far side.
    assign bus.in_ready_o  = (count != CW'(DEPTH));
    assign bus.out_valid_o = (count != '0);
    assign bus.count_o     = count;

    // Full blocks a push even when a pop frees a slot in the same cycle.
    assign push = bus.in_valid_i & bus.in_ready_o & ~bus.flush_i;
    assign pop  = bus.out_valid_o & bus.out_ready_i & ~bus.flush_i;

    assign wdata = {bus.in_pc_i, bus.in_instr_i, bus.in_br_pred_i, bus.in_pc_pred_i};

    fetch_queue_mem #(
        .DEPTH (DEPTH),
        .W     (BW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wdata),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    // Pointer and occupancy update; flush wins over any simultaneous push/pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (bus.flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Head fields, forced to the idle bundle while the queue is empty.
    always_comb begin
        bus.out_pc_o      = '0;
        bus.out_instr_o   = NOP;
        bus.out_br_pred_o = 1'b0;
        bus.out_pc_pred_o = '0;
        if (bus.out_valid_o) begin
            bus.out_pc_o      = rdata[PC_LSB +: XLEN];
            bus.out_instr_o   = rdata[INSTR_LSB +: XLEN];
            bus.out_br_pred_o = rdata[BR_BIT];
            bus.out_pc_pred_o = rdata[PRED_LSB +: XLEN];
        end
    end

endmodule
